// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority picker; first set request
//            at or above ptr, wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int M  = 4,
    parameter int PW = (M > 1) ? $clog2(M) : 1
) (
    input  logic [M-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [M-1:0]  pick_oh,
    output logic [PW-1:0] pick_idx,
    output logic          valid
);

    always_comb begin
        int idx;
        idx      = 0;
        pick_oh  = '0;
        pick_idx = '0;
        valid    = 1'b0;
        for (int k = 0; k < M; k++) begin
            idx = (int'(ptr) + k) % M;
            if (!valid && req[idx]) begin
                valid        = 1'b1;
                pick_oh[idx] = 1'b1;
                pick_idx     = PW'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clkdiv_arb.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_arb
// Purpose  : Round-robin owner arbitration and settle sequencing for one
//            shared glitchless programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_arb #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   req,
    input  logic [M*N-1:0] div_req,
    output logic [M-1:0]   grant,
    output logic           rdy,
    output logic [N-1:0]   div
);

    localparam int PW = $clog2(M);
    localparam int CW = N + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]    r_state, n_state;
    logic [CW-1:0] r_cnt,   n_cnt;
    logic [PW-1:0] r_ptr,   n_ptr;
    logic [PW-1:0] r_owner, n_owner;
    logic [M-1:0]  r_grant, n_grant;
    logic          r_rdy,   n_rdy;
    logic [N-1:0]  r_div,   n_div;

    logic [M-1:0]  w_pick_oh;
    logic [PW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic [N-1:0]  w_ratio;
    logic [N-1:0]  w_prev_floor;
    logic [CW-1:0] w_settle;
    logic [CW-1:0] w_cnt_dec;
    logic          w_owner_req;
    logic          w_cnt_last;

    rr_pick #(.M(M), .PW(PW)) u_pick (
        .req      (req),
        .ptr      (r_ptr),
        .pick_oh  (w_pick_oh),
        .pick_idx (w_pick_idx),
        .valid    (w_pick_valid)
    );

    // r_div still holds the outgoing ratio at the grant edge, so it is "prev".
    assign w_ratio      = div_req[int'(w_pick_idx)*N +: N];
    assign w_prev_floor = (r_div == '0) ? N'(1) : r_div;
    assign w_settle     = {1'b0, w_prev_floor} + CW'(1);
    assign w_cnt_dec    = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
    assign w_cnt_last   = (r_cnt <= CW'(1));
    assign w_owner_req  = req[r_owner];

    always_comb begin
        n_state = r_state;
        n_cnt   = r_cnt;
        n_ptr   = r_ptr;
        n_owner = r_owner;
        n_grant = r_grant;
        n_rdy   = r_rdy;
        n_div   = r_div;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    n_state = ST_SETTLE;
                    n_grant = w_pick_oh;
                    n_owner = w_pick_idx;
                    n_div   = w_ratio;
                    n_cnt   = w_settle;
                    n_ptr   = (w_pick_idx == PW'(M-1)) ? '0 : w_pick_idx + PW'(1);
                end
            end
            ST_SETTLE: begin
                n_cnt = w_cnt_dec;
                if (!w_owner_req) begin
                    n_state = ST_DRAIN;
                    n_grant = '0;
                end else if (w_cnt_last) begin
                    n_state = ST_HOLD;
                    n_rdy   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_owner_req) begin
                    n_state = ST_IDLE;
                    n_grant = '0;
                    n_rdy   = 1'b0;
                end
            end
            ST_DRAIN: begin
                // The divider may still be mid-update; wait out the settle time.
                n_cnt = w_cnt_dec;
                if (w_cnt_last) begin
                    n_state = ST_IDLE;
                end
            end
            default: begin
                n_state = ST_IDLE;
                n_grant = '0;
                n_rdy   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_rdy   <= 1'b0;
            r_div   <= '0;
        end else begin
            r_state <= n_state;
            r_cnt   <= n_cnt;
            r_ptr   <= n_ptr;
            r_owner <= n_owner;
            r_grant <= n_grant;
            r_rdy   <= n_rdy;
            r_div   <= n_div;
        end
    end

    assign grant = r_grant;
    assign rdy   = r_rdy;
    assign div   = r_div;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv_arb
// Purpose  : Scoreboard bench for clkdiv_arb (N=4, M=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] div_req = '0;
    logic [3:0]  grant;
    logic        rdy;
    logic [3:0]  div;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    clkdiv_arb #(.N(4), .M(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .div_req (div_req),
        .grant   (grant),
        .rdy     (rdy),
        .div     (div)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ratio(input int idx, input logic [3:0] v);
        div_req[idx*4 +: 4] = v;
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        while (!rdy && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!rdy) check_val("rdy_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [3:0] rr_order [4];
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b1000;
        rr_order[3] = 4'b0001;

        // Reset held with every request raised: nothing may be granted.
        rst     = 1'b1;
        req     = 4'b1111;
        div_req = 16'hFFFF;
        repeat (3) begin
            push("rst_grant", 0); push("rst_rdy", 0); push("rst_div", 0);
            tick();
            pop_check(32'(grant)); pop_check(32'(rdy)); pop_check(32'(div));
        end
        req = '0;
        rst = 1'b0;
        tick();

        // Single request from reset, prev=0 so S=2.
        set_ratio(2, 4'd5);
        req = 4'b0100;
        push("single_grant", 4'b0100); push("single_div", 5); push("single_rdy0", 0);
        tick();
        pop_check(32'(grant)); pop_check(32'(div)); pop_check(32'(rdy));
        push("single_rdy1", 0);
        tick();
        pop_check(32'(rdy));
        push("single_rdy2", 1);
        tick();
        pop_check(32'(rdy));
        req = '0;
        push("single_rel_grant", 0); push("single_rel_rdy", 0); push("single_keep_div", 5);
        tick();
        pop_check(32'(grant)); pop_check(32'(rdy)); pop_check(32'(div));

        // Round robin over req=1011.
        do_reset();
        div_req = 16'h1111;
        req     = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            push("rr_grant", 32'(rr_order[k]));
            tick();
            pop_check(32'(grant));
            wait_rdy(c);
            tick();
            req = req & ~rr_order[k];
            push("rr_idle_gap", 0);
            tick();
            pop_check(32'(grant));
            req = (k < 3) ? (req | rr_order[k]) : 4'b0000;
        end

        // Settle length after a ratio-9 owner: S = 10.
        do_reset();
        set_ratio(0, 4'd9);
        req = 4'b0001;
        push("sl_grant0", 4'b0001);
        tick();
        pop_check(32'(grant));
        wait_rdy(c);
        req = '0;
        tick();
        set_ratio(1, 4'd3);
        req = 4'b0010;
        push("sl_grant1", 4'b0010); push("sl_div", 3);
        tick();
        pop_check(32'(grant)); pop_check(32'(div));
        wait_rdy(c);
        push("sl_cycles", 10);
        pop_check(32'(c));
        req = '0;
        tick();

        // Leave prev=12 in the divider.
        set_ratio(2, 4'd12);
        req = 4'b0100;
        push("pre_grant", 4'b0100);
        tick();
        pop_check(32'(grant));
        wait_rdy(c);
        req = '0;
        tick();

        // Release during SETTLE with req[3] pending: S=13, regrant at cycle 14.
        set_ratio(2, 4'd4);
        set_ratio(3, 4'd6);
        req = 4'b0100;
        push("dr_grant", 4'b0100);
        tick();
        pop_check(32'(grant));
        req = 4'b1100;
        tick();
        tick();
        req = 4'b1000;
        push("dr_release", 0);
        tick();
        pop_check(32'(grant));
        c = 3;
        while (grant == '0 && c < 40) begin
            tick();
            c++;
        end
        push("dr_regrant_cycle", 14); push("dr_regrant", 4'b1000); push("dr_div", 6);
        pop_check(32'(c)); pop_check(32'(grant)); pop_check(32'(div));

        // Freeze in HOLD, then asynchronous reset between edges.
        wait_rdy(c);
        set_ratio(3, 4'd11);
        tick();
        tick();
        push("frz_div", 6); push("frz_grant", 4'b1000); push("frz_rdy", 1);
        pop_check(32'(div)); pop_check(32'(grant)); pop_check(32'(rdy));
        #2;
        rst = 1'b1;
        #1;
        push("arst_grant", 0); push("arst_rdy", 0); push("arst_div", 0);
        pop_check(32'(grant)); pop_check(32'(rdy)); pop_check(32'(div));
        tick();
        rst = 1'b0;
        req = '0;

        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
